cdc_handshake_arbiter: RTL and testbench

- Sequences four-phase req/ack transfers across a clock-domain crossing on behalf of N local requesters in the clk_a domain.
- Round-robin arbitration shares one crossing channel among the requesters. The channel is req_out plus a held data_out bus, fed to the 2-FF synchroniser in the far domain.
- ack_in returns from the far domain. It is asynchronous to clk_a and is synchronised internally.
- Reports per-requester completion and flags a stalled far side with a timeout.

---
 rtl/cdc_handshake_arbiter_if.sv | 29 ++
 rtl/cdc_handshake_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_cdc_handshake_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_handshake_arbiter_if.sv
// Channel bundle between the local requesters / far-domain acknowledge and
// the handshake arbiter. The arbiter takes the master modport, whatever drives
// the requests and the acknowledge takes the slave modport.
interface cdc_handshake_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int GID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data_in;
  logic [N_REQ-1:0]        done;
  logic                    busy;
  logic [GID_W-1:0]        grant_id;
  logic                    req_out;
  logic [DATA_W-1:0]       data_out;
  logic                    ack_in;
  logic                    timeout_err;

  modport master (
    input  req, data_in, ack_in,
    output done, busy, grant_id, req_out, data_out, timeout_err
  );

  modport slave (
    output req, data_in, ack_in,
    input  done, busy, grant_id, req_out, data_out, timeout_err
  );
endinterface

// File: rtl/cdc_handshake_arbiter.sv
// Round-robin arbiter that shares one four-phase req/ack crossing channel
// among N_REQ local requesters. The acknowledge from the far domain is
// synchronised here; a per-phase counter flags a stalled far side.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | channel free, looking for a requester from ptr upwards
// REQ   | req_out high, payload held, waiting for a 0->1 edge of ack_s
// DROP  | req_out low, waiting for the far side to release ack
module cdc_handshake_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input logic                     clk_a,
  input logic                     rst_n,
  cdc_handshake_arbiter_if.master bus
);

  localparam int GID_W = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                   r_state;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     r_ack_s_d;
  logic [GID_W-1:0]         r_ptr;
  logic [GID_W-1:0]         r_grant_id;
  logic [DATA_W-1:0]        r_data_out;
  logic                     r_req_out;
  logic [N_REQ-1:0]         r_done;
  logic                     r_timeout_err;
  logic [CNT_W-1:0]         r_cnt;

  state_t                   w_state;
  logic [GID_W-1:0]         w_ptr;
  logic [GID_W-1:0]         w_grant_id;
  logic [DATA_W-1:0]        w_data_out;
  logic                     w_req_out;
  logic [N_REQ-1:0]         w_done;
  logic                     w_timeout_err;
  logic [CNT_W-1:0]         w_cnt;

  logic                     w_ack_s;
  logic                     w_ack_rise;
  logic                     w_tc;
  logic                     w_found;
  logic [GID_W-1:0]         w_win;
  logic [GID_W-1:0]         w_cand;
  logic [GID_W-1:0]         w_ptr_next;
  logic [DATA_W-1:0]        w_win_data;

  assign w_ack_s    = r_sync[SYNC_STAGES-1];
  // Only a fresh rising edge counts, so an ack left high from a previous
  // phase (or a spurious one seen in IDLE) can never complete a transfer.
  assign w_ack_rise = w_ack_s & ~r_ack_s_d;
  assign w_tc       = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_ptr_next = (r_grant_id == GID_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
  assign w_win_data = bus.data_in[int'(w_win)*DATA_W +: DATA_W];

  // Synchronise the asynchronous far-domain acknowledge and keep a delayed copy for edge detection
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_ack_s_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.ack_in};
      r_ack_s_d <= w_ack_s;
    end
  end

  // Round-robin search: first asserted request at or above ptr, wrapping
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = GID_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // State and channel registers
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_grant_id    <= '0;
      r_data_out    <= '0;
      r_req_out     <= 1'b0;
      r_done        <= '0;
      r_timeout_err <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state;
      r_ptr         <= w_ptr;
      r_grant_id    <= w_grant_id;
      r_data_out    <= w_data_out;
      r_req_out     <= w_req_out;
      r_done        <= w_done;
      r_timeout_err <= w_timeout_err;
      r_cnt         <= w_cnt;
    end
  end

  // Next-state and registered-output logic; done/timeout_err default low so they only pulse
  always_comb begin
    w_state       = r_state;
    w_ptr         = r_ptr;
    w_grant_id    = r_grant_id;
    w_data_out    = r_data_out;
    w_req_out     = r_req_out;
    w_done        = '0;
    w_timeout_err = 1'b0;
    w_cnt         = r_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_id = w_win;
          w_data_out = w_win_data;
          w_req_out  = 1'b1;
          w_cnt      = '0;
          w_state    = ST_REQ;
        end
      end

      ST_REQ: begin
        w_cnt = r_cnt + 1'b1;
        if (w_ack_rise) begin
          w_req_out          = 1'b0;
          w_done[r_grant_id] = 1'b1;
          w_ptr              = w_ptr_next;
          w_cnt              = '0;
          w_state            = ST_DROP;
        end else if (w_tc) begin
          // Abandon this requester and move on so a dead far side cannot starve the others.
          w_req_out     = 1'b0;
          w_timeout_err = 1'b1;
          w_ptr         = w_ptr_next;
          w_cnt         = '0;
          w_state       = ST_DROP;
        end
      end

      ST_DROP: begin
        w_cnt = r_cnt + 1'b1;
        if (!w_ack_s) begin
          w_cnt   = '0;
          w_state = ST_IDLE;
        end else if (w_tc) begin
          w_timeout_err = 1'b1;
          w_cnt         = '0;
          w_state       = ST_IDLE;
        end
      end

      default: begin
        w_req_out = 1'b0;
        w_cnt     = '0;
        w_state   = ST_IDLE;
      end
    endcase
  end

  assign bus.done        = r_done;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.grant_id    = r_grant_id;
  assign bus.req_out     = r_req_out;
  assign bus.data_out    = r_data_out;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// Scoreboard bench for cdc_handshake_arbiter: expected grants and completions
// are queued when requests are driven and checked by a monitor as the DUT
// produces them. A far-side model acknowledges req_out with a 3-cycle delay.
module tb_cdc_handshake_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 20;

  typedef struct packed {
    logic [1:0]    gid;
    logic [DW-1:0] data;
  } grant_t;

  logic clk_a = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_a = ~clk_a;

  cdc_handshake_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  cdc_handshake_arbiter #(
    .N_REQ(N), .DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT(TO)
  ) dut (
    .clk_a (clk_a),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int        n_err = 0;
  int        n_chk = 0;
  int        cyc   = 0;
  grant_t    grant_q[$];
  logic [4:0] cmp_q[$];
  int        done_cnt[N];
  int        grant_cnt[N];
  logic [2:0] sh = '0;
  int        ack_mode = 0;   // 0: follow req_out after 3 cycles, 1: stuck 0, 2: stuck 1
  bit        auto_clr = 1'b1;
  logic      prev_req_out = 1'b0;
  logic [DW-1:0] exp_data = '0;

  always @(posedge clk_a) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Far-side model: ack follows req_out three cycles later, or is held stuck
  always @(negedge clk_a) begin
    sh = {sh[1:0], bus.req_out};
    case (ack_mode)
      1:       bus.ack_in = 1'b0;
      2:       bus.ack_in = 1'b1;
      default: bus.ack_in = sh[2];
    endcase
  end

  // Monitor: pops the scoreboard on each new grant and each done/timeout pulse
  always @(negedge clk_a) begin
    if (rst_n) begin
      if (bus.req_out && !prev_req_out) begin
        grant_cnt[bus.grant_id]++;
        if (grant_q.size() == 0) chk("grant_unexpected", 32'(bus.grant_id), 32'hff);
        else begin
          grant_t g;
          g = grant_q.pop_front();
          chk("grant_id", 32'(bus.grant_id), 32'(g.gid));
          chk("grant_data", 32'(bus.data_out), 32'(g.data));
          exp_data = g.data;
        end
      end else if (bus.req_out) begin
        chk("data_hold", 32'(bus.data_out), 32'(exp_data));
      end
      if (bus.done != '0 || bus.timeout_err) begin
        for (int i = 0; i < N; i++) if (bus.done[i]) done_cnt[i]++;
        if (cmp_q.size() == 0) chk("completion_unexpected", 32'({bus.timeout_err, bus.done}), 32'hff);
        else chk("completion", 32'({bus.timeout_err, bus.done}), 32'(cmp_q.pop_front()));
      end
    end
    prev_req_out = bus.req_out;
  end

  task automatic push_grant(input int i);
    grant_t g;
    g.gid  = 2'(i);
    g.data = bus.data_in[i*DW +: DW];
    grant_q.push_back(g);
  endtask

  task automatic push_done(input int i);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    cmp_q.push_back({1'b0, oh});
  endtask

  task automatic push_timeout();
    cmp_q.push_back(5'b10000);
  endtask

  task automatic wait_events(input int n, input int budget);
    int seen = 0;
    int c = 0;
    while (seen < n && c < budget) begin
      @(negedge clk_a);
      c++;
      if (bus.done != '0 || bus.timeout_err) begin
        seen++;
        if (auto_clr) bus.req = bus.req & ~bus.done;
      end
    end
    if (seen < n) chk("wait_events_budget", 32'(seen), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    do begin
      @(negedge clk_a);
      c++;
    end while (bus.busy && c < budget);
    chk("idle", 32'(bus.busy), 0);
  endtask

  task automatic wait_req_out(input int budget);
    int c = 0;
    do begin
      @(negedge clk_a);
      c++;
    end while (!bus.req_out && c < budget);
    chk("req_out_rise", 32'(bus.req_out), 1);
  endtask

  task automatic do_reset();
    @(negedge clk_a);
    rst_n = 1'b0;
    repeat (5) @(negedge clk_a);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base[N];
    int g1, t0, t1;

    bus.req     = '0;
    bus.data_in = {8'h40, 8'h30, 8'h20, 8'hA5};

    // Reset state
    repeat (3) @(negedge clk_a);
    chk("rst_req_out", 32'(bus.req_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_grant_id", 32'(bus.grant_id), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_data_out", 32'(bus.data_out), 0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 0);
    rst_n = 1'b1;
    @(negedge clk_a);

    // Single request
    base[0] = done_cnt[0];
    push_grant(0);
    push_done(0);
    bus.req = 4'b0001;
    @(negedge clk_a);
    chk("req_out_latency", 32'(bus.req_out), 1);
    chk("data_out_a5", 32'(bus.data_out), 32'hA5);
    wait_events(1, 100);
    wait_idle(100);
    repeat (5) @(negedge clk_a);
    chk("no_regrant", 32'(bus.req_out), 0);
    chk("busy_after", 32'(bus.busy), 0);
    chk("done0_once", 32'(done_cnt[0] - base[0]), 1);

    // Round-robin fairness from a fresh pointer
    do_reset();
    bus.data_in = {8'h40, 8'h30, 8'h20, 8'h10};
    for (int i = 0; i < N; i++) base[i] = done_cnt[i];
    for (int k = 0; k < 8; k++) begin
      push_grant(k % N);
      push_done(k % N);
    end
    auto_clr = 1'b0;
    bus.req  = 4'b1111;
    wait_events(8, 400);
    bus.req  = '0;
    auto_clr = 1'b1;
    wait_idle(100);
    for (int i = 0; i < N; i++) chk("rr_done_twice", 32'(done_cnt[i] - base[i]), 2);

    // Pointer wrap and skipping
    push_grant(2);
    push_done(2);
    bus.req = 4'b0100;
    wait_events(1, 100);
    wait_idle(100);
    push_grant(3);
    push_done(3);
    push_grant(0);
    push_done(0);
    bus.req = 4'b1001;
    wait_events(2, 200);
    wait_idle(100);

    // Request withdrawn before grant, and after grant
    g1 = grant_cnt[1];
    push_grant(0);
    push_done(0);
    bus.req = 4'b0001;
    wait_req_out(50);
    bus.req = 4'b0011;
    @(negedge clk_a);
    bus.req = 4'b0001;
    wait_events(1, 100);
    wait_idle(100);
    chk("withdrawn_not_granted", 32'(grant_cnt[1] - g1), 0);
    push_grant(2);
    push_done(2);
    bus.req = 4'b0100;
    wait_req_out(50);
    bus.req = '0;
    wait_events(1, 100);
    wait_idle(100);

    // Timeout in REQ with ack stuck low; next requester still served
    ack_mode = 1;
    push_grant(0);
    push_timeout();
    push_grant(1);
    push_timeout();
    bus.req = 4'b0011;
    wait_req_out(50);
    t0 = cyc;
    wait_events(1, 100);
    chk("to_req_cycles", 32'(cyc - t0), TO);
    chk("to_req_out_low", 32'(bus.req_out), 0);
    wait_events(1, 100);
    bus.req = '0;
    wait_idle(100);

    // Ack stuck high: timeout in REQ, then a second one in DROP
    ack_mode = 2;
    repeat (4) @(negedge clk_a);
    push_grant(2);
    push_timeout();
    push_timeout();
    bus.req = 4'b0100;
    wait_events(1, 100);
    t1 = cyc;
    bus.req = '0;
    wait_events(1, 100);
    chk("to_drop_cycles", 32'(cyc - t1), TO);
    chk("to_drop_idle", 32'(bus.busy), 0);
    ack_mode = 0;
    repeat (6) @(negedge clk_a);

    // Mid-transfer reset, then re-grant from index 0
    push_grant(3);
    bus.req = 4'b1001;
    wait_req_out(50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req_out", 32'(bus.req_out), 0);
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_grant_id", 32'(bus.grant_id), 0);
    repeat (5) @(negedge clk_a);
    push_grant(0);
    push_done(0);
    push_grant(3);
    push_done(3);
    rst_n = 1'b1;
    wait_events(2, 200);
    wait_idle(100);

    repeat (5) @(negedge clk_a);
    chk("grant_q_empty", 32'(grant_q.size()), 0);
    chk("cmp_q_empty", 32'(cmp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
